// File: rtl/tt_um_winston_prbs_checker_pkg.sv
// PRBS31 checker shared definitions: polynomial taps, FSM states, counter widths.
// Optional build macro used by the top: PRBS_CHK_POLINV_EN.
package prbs_pkg;

  // x^31 + x^28 + 1, register bit 0 holds the newest bit
  localparam int unsigned PRBS_LEN = 31;
  localparam int unsigned TAP_A    = 27;
  localparam int unsigned TAP_B    = 30;

  localparam int unsigned ERR_W  = 16;
  localparam int unsigned FILL_W = 5;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'b00,
    ST_VERIFY = 2'b01,
    ST_LOCKED = 2'b10
  } state_t;

  // Width of a counter that must hold values 0..max_val
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tt_um_winston_prbs_checker_if.sv
// Link between the checker FSM and the PRBS31 predictor.
//   shift_en : advance the predictor register this cycle
//   rx       : received bit (after optional polarity invert)
//   state    : checker state, selects shift-in source
//   pred     : predicted next bit
interface tt_um_winston_prbs_checker_if;
  import prbs_pkg::*;

  logic   shift_en;
  logic   rx;
  state_t state;
  logic   pred;

  modport master (output shift_en, output rx, output state, input pred);
  modport slave  (input shift_en, input rx, input state, output pred);
endinterface

// File: rtl/tt_um_winston_prbs_checker_predictor.sv
// PRBS31 predictor: holds the 31-bit history register and predicts the next bit.
// Ports: clk, rst_n (async active-low), link (slave side of the checker link).
module prbs31_predictor
  import prbs_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  tt_um_winston_prbs_checker_if.slave  link
);

  logic [PRBS_LEN-1:0] r_q, r_d;
  logic                in_bit_c;

  assign link.pred = r_q[TAP_A] ^ r_q[TAP_B];

  // Once locked the register free-runs on its own prediction, so a single
  // line error is not echoed into later predictions.
  assign in_bit_c = (link.state == ST_LOCKED) ? link.pred : link.rx;

  always_comb begin
    r_d = r_q;
    if (link.shift_en) r_d = {r_q[PRBS_LEN-2:0], in_bit_c};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= r_d;
  end

endmodule

// File: rtl/tt_um_winston_prbs_checker.sv
// PRBS31 (x^31 + x^28 + 1) serial checker, Tiny Tapeout tile.
// Hunts/verifies/locks on an incoming stream, then counts bit errors.
// Ports: ui_in[0] rx, [1] valid, [2] clear count, [3] polarity invert,
//        [4] count byte select; uo_out[0] locked, [1] error pulse,
//        [2] saturated, [4:3] state; uio_out count byte; uio_oe = 8'hFF.
// Build macro PRBS_CHK_POLINV_EN: XOR rx with ui_in[3] before processing.
module tt_um_winston_prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LOCK_CNT    = 64,
  parameter int unsigned WIN_LEN     = 128,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  localparam int unsigned MATCH_W = cnt_width(LOCK_CNT);
  localparam int unsigned WIN_W   = cnt_width(WIN_LEN);
  localparam int unsigned WERR_W  = cnt_width(LOSS_THRESH);

  logic rx_c, vld_c, clr_c, sel_c, mis_c, win_last_c, unused_c;

`ifdef PRBS_CHK_POLINV_EN
  assign rx_c     = ui_in[0] ^ ui_in[3];
  assign unused_c = &{1'b0, ena, uio_in, ui_in[7:5]};
`else
  assign rx_c     = ui_in[0];
  assign unused_c = &{1'b0, ena, uio_in, ui_in[7:5], ui_in[3]};
`endif
  assign vld_c = ui_in[1];
  assign clr_c = ui_in[2];
  assign sel_c = ui_in[4];

  state_t               state_q, state_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic [MATCH_W-1:0]   match_q, match_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [WERR_W-1:0]    werr_q, werr_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 sat_q, sat_d;
  logic                 pulse_q, pulse_d;

  // Predictor link
  tt_um_winston_prbs_checker_if link ();
  assign link.shift_en = vld_c;
  assign link.rx       = rx_c;
  assign link.state    = state_q;

  prbs31_predictor u_pred (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  assign mis_c      = rx_c ^ link.pred;
  assign win_last_c = (win_q == WIN_W'(WIN_LEN - 1));

  // Next-state: FSM, lock/window counters, error count
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
    win_d   = win_q;
    werr_d  = werr_q;
    err_d   = err_q;
    sat_d   = sat_q;
    pulse_d = 1'b0;

    if (vld_c) begin
      case (state_q)
        ST_HUNT: begin
          if (fill_q == FILL_W'(PRBS_LEN - 1)) begin
            state_d = ST_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        ST_VERIFY: begin
          if (mis_c) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          win_d  = win_last_c ? '0 : win_q + WIN_W'(1);
          werr_d = win_last_c ? '0 : werr_q;
          if (mis_c) begin
            pulse_d = 1'b1;
            if (err_q != '1) err_d = err_q + ERR_W'(1);
            // The error on the window's last bit still counts toward loss
            if (werr_q == WERR_W'(LOSS_THRESH - 1)) begin
              state_d = ST_HUNT;
              fill_d  = '0;
            end else if (!win_last_c) begin
              werr_d = werr_q + WERR_W'(1);
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end

    sat_d = sat_q | (err_d == '1);
    if (clr_c) begin
      err_d = '0;
      sat_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      sat_q   <= sat_d;
      pulse_q <= pulse_d;
    end
  end

  // Pin mapping; only the count byte mux is combinational
  assign uo_out  = {3'b000, state_q, sat_q, pulse_q, (state_q == ST_LOCKED)};
  assign uio_out = sel_c ? err_q[15:8] : err_q[7:0];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_winston_prbs_checker.sv
// Self-checking bench for the PRBS31 checker tile.
module tb_tt_um_winston_prbs_checker;

  localparam int LOCK_CNT    = 64;
  localparam int WIN_LEN     = 128;
  localparam int LOSS_THRESH = 8;
`ifdef PRBS_CHK_POLINV_EN
  localparam bit POLINV = 1'b1;
`else
  localparam bit POLINV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  wire  [7:0] uo_out, uio_out, uio_oe;

  always #5 clk = ~clk;

  tt_um_winston_prbs_checker dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  int checks = 0;
  int failures = 0;

  // Stream source: PRBS31 generator
  logic [30:0] g;
  function automatic bit gen_bit();
    bit b;
    b = g[27] ^ g[30];
    g = {g[29:0], b};
    return b;
  endfunction
  function automatic bit gen_peek();
    return g[27] ^ g[30];
  endfunction

  // Reference model: mode 0 hunt, 1 verify, 2 locked; history queue of last 31 bits
  int m_mode, m_fill, m_streak, m_nbits, m_werr, m_cnt;
  bit m_sat, m_pulse;
  bit m_hist[$];

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_streak = 0; m_nbits = 0; m_werr = 0; m_cnt = 0;
    m_sat = 0; m_pulse = 0;
    m_hist.delete();
    repeat (31) m_hist.push_back(1'b0);
  endtask

  task automatic hist_push(input bit b);
    m_hist.push_back(b);
    void'(m_hist.pop_front());
  endtask

  task automatic model_step(input bit rx, input bit vld, input bit clr);
    bit p;
    p = m_hist[3] ^ m_hist[0];   // bits 28 and 31 back
    m_pulse = 0;
    if (vld) begin
      if (m_mode == 0) begin
        hist_push(rx);
        m_fill++;
        if (m_fill == 31) begin m_mode = 1; m_streak = 0; end
      end else if (m_mode == 1) begin
        hist_push(rx);
        m_streak = (rx == p) ? m_streak + 1 : 0;
        if (m_streak == LOCK_CNT) begin m_mode = 2; m_nbits = 0; m_werr = 0; end
      end else begin
        hist_push(p);
        m_nbits++;
        if (rx != p) begin
          m_pulse = 1;
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt == 65535) m_sat = 1;
          m_werr++;
        end
        if (m_werr == LOSS_THRESH) begin
          m_mode = 0; m_fill = 0;
        end else if (m_nbits == WIN_LEN) begin
          m_nbits = 0; m_werr = 0;
        end
      end
    end
    if (clr) begin m_cnt = 0; m_sat = 0; end
  endtask

  function automatic logic [7:0] exp_uo();
    return {3'b000, 2'(m_mode), m_sat, m_pulse, (m_mode == 2)};
  endfunction

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock with model comparison
  task automatic cycle(input bit rx, input bit vld, input bit clr, input bit sel, input bit pol);
    ui_in = {3'b000, sel, pol, clr, vld, rx};
    @(posedge clk); #1;
    model_step(rx ^ (POLINV & pol), vld, clr);
    check8("uo_out", uo_out, exp_uo());
    check8("uio_out", uio_out, sel ? 8'(m_cnt >> 8) : 8'(m_cnt));
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) cycle(gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    ui_in = 8'h00;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    g = 31'd1;
  endtask

  typedef struct {
    logic [7:0] ui;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
  } vec_t;

  vec_t idle_vecs[5];
  vec_t byte_vecs[4];

  task automatic apply_vec(input string nm, input vec_t v);
    ui_in = v.ui;
    @(posedge clk); #1;
    model_step(v.ui[0] ^ (POLINV & v.ui[3]), v.ui[1], v.ui[2]);
    check8({nm, "_uo"}, uo_out, v.exp_uo);
    check8({nm, "_uio"}, uio_out, v.exp_uio);
  endtask

  initial begin
    int lock_at, pulses, errs, nvalid;
    bit flip, b;

    // Valid=0 vectors after reset: nothing moves
    idle_vecs[0] = '{8'h00, 8'h00, 8'h00};
    idle_vecs[1] = '{8'h01, 8'h00, 8'h00};
    idle_vecs[2] = '{8'h05, 8'h00, 8'h00};
    idle_vecs[3] = '{8'h19, 8'h00, 8'h00};
    idle_vecs[4] = '{8'hE1, 8'h00, 8'h00};
    // Locked with count 300: byte select, valid=0
    byte_vecs[0] = '{8'h00, 8'h11, 8'h2C};
    byte_vecs[1] = '{8'h10, 8'h11, 8'h01};
    byte_vecs[2] = '{8'hE0, 8'h11, 8'h2C};
    byte_vecs[3] = '{8'hF9, 8'h11, 8'h01};

    // Reset values
    #12;
    check8("rst_uo", uo_out, 8'h00);
    check8("rst_uio", uio_out, 8'h00);
    check8("rst_oe", uio_oe, 8'hFF);
    do_reset();
    foreach (idle_vecs[i]) apply_vec("idle", idle_vecs[i]);

    // Clean stream from seed 1: lock after the 95th bit, no errors after 1000
    lock_at = -1;
    for (int i = 1; i <= 1000; i++) begin
      cycle(gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (lock_at < 0 && uo_out[0]) lock_at = i;
    end
    check_int("lock_bit", lock_at, 95);
    check8("clean_state", {6'b0, uo_out[4:3]}, 8'h02);
    check8("clean_cnt", uio_out, 8'h00);

    // Single flipped bit: one pulse, count 1, lock held
    pulses = 0;
    for (int i = 1; i <= 520; i++) begin
      b = gen_bit();
      cycle(b ^ (i == 500), 1'b1, 1'b0, 1'b0, 1'b0);
      if (uo_out[1]) pulses++;
    end
    check_int("one_pulse", pulses, 1);
    check8("one_cnt", uio_out, 8'h01);
    check8("one_lock", {7'b0, uo_out[0]}, 8'h01);

    // Eight errors in one window: lose lock on the 8th, then relock in 95 bits
    for (int i = 0; i < WIN_LEN && m_nbits != 0; i++) clean(1);
    for (int i = 0; i < WIN_LEN && m_nbits != 10; i++) clean(1);
    cycle(gen_bit(), 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cycle(~gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (k < 7) clean(1);
    end
    check8("loss_state", {6'b0, uo_out[4:3]}, 8'h00);
    check8("loss_cnt", uio_out, 8'h08);
    for (int i = 1; i <= 95; i++) begin
      clean(1);
      if (i == 94) check8("relock_94", {7'b0, uo_out[0]}, 8'h00);
    end
    check8("relock_95", {7'b0, uo_out[0]}, 8'h01);

    // 300 errors at 7 per window, lock held
    cycle(gen_bit(), 1'b1, 1'b1, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < 10000 && errs < 300; i++) begin
      flip = (m_mode == 2) && (m_nbits >= 10) && (m_nbits < 17);
      cycle(gen_bit() ^ flip, 1'b1, 1'b0, 1'b0, 1'b0);
      if (flip) errs++;
    end
    clean(1);
    foreach (byte_vecs[i]) apply_vec("byte", byte_vecs[i]);

    // Asynchronous reset mid-cycle while locked
    ui_in = 8'h10;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check8("async_uo", uo_out, 8'h00);
    check8("async_uio", uio_out, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    g = 31'd1;

    // Valid every other cycle, wrong data on idle cycles
    lock_at = -1;
    nvalid = 0;
    for (int i = 0; i < 400 && lock_at < 0; i++) begin
      if (i % 2 == 0) begin
        cycle(gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
        nvalid++;
        if (uo_out[0]) lock_at = nvalid;
      end else begin
        cycle(~gen_peek(), 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    check_int("alt_lock", lock_at, 95);
    clean(5);
    check8("alt_noerr", uio_out, 8'h00);

    // Clear on the same cycle as an error
    cycle(~gen_bit(), 1'b1, 1'b1, 1'b0, 1'b0);
    check8("clr_cnt", uio_out, 8'h00);
    check8("clr_pulse", {7'b0, uo_out[1]}, 8'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit vld, clr, sel;
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      sel = 1'($urandom);
      if (vld) b = gen_bit() ^ ($urandom_range(0, 63) == 0);
      else     b = 1'($urandom);
      cycle(b, vld, clr, sel, 1'b0);
    end

`ifdef PRBS_CHK_POLINV_EN
    // Inverted stream with invert enabled locks cleanly
    do_reset();
    for (int i = 0; i < 200; i++) cycle(~gen_bit(), 1'b1, 1'b0, 1'b0, 1'b1);
    check8("inv_lock", {7'b0, uo_out[0]}, 8'h01);
    check8("inv_cnt", uio_out, 8'h00);
    // Inverted stream without invert never locks
    do_reset();
    lock_at = 0;
    for (int i = 0; i < 500; i++) begin
      cycle(~gen_bit(), 1'b1, 1'b0, 1'b0, 1'b0);
      if (uo_out[0]) lock_at = 1;
    end
    check_int("inv_nolock", lock_at, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_winston_prbs_checker.md
# tt_um_winston_prbs_checker

PRBS31 (x^31 + x^28 + 1) serial pattern checker; the receive end of the team's PRBS31 generator tile. It self-synchronises to an incoming bit stream, declares lock, then counts bit errors against a free-running local predictor. Tiny Tapeout top-level, standard `tt_um_` pin frame.

## Interface
Parameters:
- LOCK_CNT, 64: consecutive correct predictions required in VERIFY to declare lock
- WIN_LEN, 128: loss-of-lock observation window, in valid bits
- LOSS_THRESH, 8: errors within one window that force re-hunt

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  unused
- ui_in  in  8  [0] rx bit; [1] bit valid; [2] clear error count (sync); [3] polarity invert (see Configuration); [4] count byte select (0 = low, 1 = high); [7:5] unused
- uio_in  in  8  unused
- uo_out  out  8  [0] locked; [1] error pulse; [2] count saturated; [4:3] state (00 HUNT, 01 VERIFY, 10 LOCKED); [7:5] 0
- uio_out  out  8  selected byte of 16-bit error count
- uio_oe  out  8  constant 8'hFF

## Operation
- Only cycles with ui_in[1]=1 are processed; valid=0 cycles change nothing except clear.
- 31-bit register r; r[0] newest bit. Prediction p = r[27] ^ r[30].
- HUNT: shift rx into r; 5-bit fill counter; after the 31st valid bit -> VERIFY, match counter = 0.
- VERIFY: shift rx (not p) into r; rx==p increments match counter, mismatch clears it (stay in VERIFY). At LOCK_CNT-th consecutive match -> LOCKED; window and window-error counters cleared.
- LOCKED: shift p into r (free-running; one line error counts once). rx!=p: error pulse, error count +1, window-error +1. Window counter counts valid bits; at WIN_LEN it wraps and clears window-error. Window-error reaching LOSS_THRESH -> HUNT, fill counter = 0; that error is still counted.
- Error count: 16-bit, saturates at 16'hFFFF; saturated flag set at saturation, cleared only by clear/reset.
- Clear (ui_in[2]=1): zeroes error count and saturated flag; wins over a same-cycle increment; lock state untouched.
- Errors are counted only in LOCKED.

## Timing
- Reset values: r=0, state HUNT, all counters 0, uo_out=8'h00, uio_out=8'h00; uio_oe=8'hFF always.
- All outputs registered except uio_out byte mux (combinational from ui_in[4] and count register).
- Error pulse: high exactly one cycle, in the cycle after the erroneous bit is sampled.
- Clean stream, valid every cycle: locked rises after the edge sampling the 95th valid bit (31 fill + 64 match).
- State change to HUNT is visible after the edge sampling the LOSS_THRESH-th windowed error.
- Reset mid-operation: immediate return to reset values regardless of clock.

## Configuration
- PRBS_CHK_POLINV_EN defined: rx bit XORed with ui_in[3] before all processing (accepts inverted streams).
- Undefined: ui_in[3] ignored, folded into the unused-input sink; no XOR in the path.

## Structure
- Package prbs_pkg: PRBS31 length (31) and tap indices (27, 30), state enum (HUNT/VERIFY/LOCKED, 2-bit), error-count width (16), fill/match/window counter widths.
- One sub-module, prbs31_predictor: holds r, selects shift-in source (rx or p) by state, outputs p; top holds FSM, counters, pin mapping.

## Test plan
- Reset, generator seed 1 streamed with valid every cycle -> uo_out[0]=1 after 95th bit; after 1000 bits count=0, state=10.
- Locked, flip bit 500 -> single one-cycle uo_out[1] pulse, count=1, lock held.
- Locked, flip 8 bits within 128 valid bits -> state 00 after 8th flip, count=8; 95 further clean bits -> relocked.
- Valid alternating 1/0 -> lock after 95 valid bits (~190 cycles); data during valid=0 (forced wrong) causes no errors.
- Count 300 errors (7 per window), ui_in[4]=0 -> uio_out=8'h2C, ui_in[4]=1 -> 8'h01; pulse clear same cycle as an error -> count 0; rst_n low while locked -> uo_out=0 immediately.
- With PRBS_CHK_POLINV_EN: inverted stream, ui_in[3]=1 -> locks, 0 errors; ui_in[3]=0 -> no lock in 500 bits.
